fp_addsub_param: RTL and testbench
==================================

// Module: fp_addsub_param
// PURPOSE
//  Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor, successor to the fixed
//  single-precision FSM adder. Adds runtime add/sub select, valid/ready handshakes on both sides,
//  single-cycle barrel alignment with guard/round/sticky, optional round-to-nearest-even.
//  Sits between the operand issue stage and the result writeback in the FP datapath.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W  23  stored mantissa field width (hidden bit excluded); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  asynchronous, active-high reset
//  in_valid   in   1  op_a/op_b/sub valid
//  in_ready   out  1  block idle, will accept; = (state==IDLE) && !reset
//  op_a       in   W  operand A
//  op_b       in   W  operand B
//  sub        in   1  1: z = a - b (b sign inverted at accept); 0: z = a + b
//  out_valid  out  1  out_z/ofw hold a result
//  out_ready  in   1  consumer takes result
//  out_z      out  W  result
//  ofw        out  1  result overflowed to infinity (not set for inf/NaN operands)
// BEHAVIOUR
//  Reset (async): state=IDLE, out_valid=0, out_z=0, ofw=0, all internal regs 0. Mid-operation reset
//   aborts the op; no result is emitted.
//  Accept: in_valid&&in_ready at an edge registers and unpacks operands; in_ready drops next cycle.
//  States: IDLE -> SPECIAL -> ALIGN -> ADD -> NORM(1+k cycles) -> ROUND -> DONE -> IDLE.
//   SPECIAL: NaN operand, or inf+(-inf) after sub -> z = canonical qNaN {0,all-ones,1,0...}; one inf
//    -> that inf with its sign; A zero -> B (effective sign); B zero -> A; both zero -> +0 unless
//    both negative (-0). Specials jump straight to DONE, ofw=0.
//    Exponent 0 (subnormal): treat exponent as 1, hidden bit 0; else hidden bit 1.
//   ALIGN: smaller-exponent mantissa right-shifted by diff in one cycle into MAN_W+4 bits
//    (hidden, MAN_W, G, R); shifted-out bits OR into S. diff > MAN_W+3 -> mantissa becomes S=1 only.
//   ADD: equal effective signs add, else larger magnitude minus smaller; sign from larger
//    magnitude; exact cancellation -> +0. Carry-out -> shift right 1 (OR into S), exp+1, same cycle.
//   NORM: while MSB==0 && exp>1, shift left 1, exp-1, one bit per cycle (k = shifts done).
//   ROUND: applies rounding (see CONFIGURATION); round carry renormalises (exp+1). exp >= 2^EXP_W-1
//    -> z = inf with result sign, ofw=1. MSB==0 with exp==1 -> packed exponent 0 (subnormal).
//  Latency (accepting edge = edge 1): out_valid rises after edge 6+k normal path, edge 2 specials.
//  DONE: out_valid=1, out_z/ofw stable; out_ready high at an edge -> IDLE, out_valid=0 next cycle.
//   No accept while DONE (no same-cycle drain+accept). out_z/ofw hold last value after drain.
//  Inputs are ignored outside the accepting edge; op_a/op_b may change freely afterwards.
// CONFIGURATION
//  FP_ADDSUB_RNE_EN defined: round-to-nearest-even: increment if G && (R||S||LSB).
//  Undefined: truncate toward zero (G/R/S discarded). ROUND state still costs one cycle in both
//   builds, so latency is identical; overflow always returns inf (never max-finite).
// TESTING (EXP_W=8, MAN_W=23)
//  0x3F800000 + 0x3F800000, sub=0 -> 0x40000000, ofw=0, out_valid after edge 6 (carry path, k=0)
//  0x3F800000 - 0x3F800000, sub=1 -> 0x00000000 (+0); 0x3FC00000 - 0x3F800000 -> 0x3F000000 (k=1, edge 7)
//  0x7F800000 + 0xFF800000 -> 0x7FC00000, ofw=0, edge 2; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, ofw=1
//  0x3F800000 + 0x34400000 -> 0x3F800002 with FP_ADDSUB_RNE_EN, 0x3F800001 without
//  0x00000001 + 0x00000001 -> 0x00000002 (subnormal in/out); hold out_ready=0 10 cycles -> out_z
//   stable, in_ready=0; release -> in_ready=1 next cycle
//  Assert reset during NORM of a cancellation op -> out_valid=0, out_z=0 immediately; next op correct

Source files
------------

// File: rtl/fp_addsub_param.sv
// Multi-cycle parametrised floating-point adder/subtractor with valid/ready handshakes.
// Optional build macro FP_ADDSUB_RNE_EN selects round-to-nearest-even; otherwise it truncates toward zero.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_z,
    output logic                   ofw
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam logic [EXP_W-1:0] E_ONE   = EXP_W'(1);
    localparam logic [EXP_W:0]   EXP_INF = {1'b0, {EXP_W{1'b1}}};
    localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_ADDSUB_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [MW-1:0]      ma_q, ma_d, mb_q, mb_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W:0]     exp_q, exp_d;
    logic [MW-1:0]      m_q, m_d;
    logic               s_q, s_d;
    logic [W-1:0]       z_q, z_d;
    logic               ofw_q, ofw_d;
    logic [MW:0]        sum_c;
    logic [W:0]         rnd_c;

    // Right shift by d into {hidden, frac, G, R, S}; everything shifted out collapses into S.
    function automatic logic [MW-1:0] align_shift(input logic [MW-1:0] m,
                                                  input logic [EXP_W-1:0] d);
        logic [MW-1:0] r;
        logic          sticky;
        sticky = 1'b0;
        if (32'(d) > 32'(MW - 1)) begin
            r = {{(MW-1){1'b0}}, 1'b1};
        end else begin
            sticky = |(m << (32'(MW) - 32'(d)));
            r = (m >> d) | {{(MW-1){1'b0}}, sticky};
        end
        return r;
    endfunction

    // Rounds a normalised {hidden, frac, G, R, S} mantissa and packs it; returns {ofw, z}.
    function automatic logic [W:0] round_pack(input logic sign, input logic [EXP_W:0] e,
                                              input logic [MW-1:0] m);
        logic [MAN_W+1:0] r;
        logic             inc;
        logic [EXP_W:0]   ee;
        logic [W:0]       res;
        inc = RNE_EN & m[2] & (m[1] | m[0] | m[3]);
        r   = {1'b0, m[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        ee  = e;
        if (r[MAN_W+1]) begin
            r  = r >> 1;
            ee = e + {{EXP_W{1'b0}}, 1'b1};
        end
        if (ee >= EXP_INF)
            res = {1'b1, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (!r[MAN_W])
            res = {1'b0, sign, {EXP_W{1'b0}}, r[MAN_W-1:0]};
        else
            res = {1'b0, sign, ee[EXP_W-1:0], r[MAN_W-1:0]};
        return res;
    endfunction

    logic [EXP_W-1:0] ea_raw, eb_raw, ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MW-1:0]    mA, mB;

    assign ea_raw = a_q[W-2:MAN_W];
    assign eb_raw = b_q[W-2:MAN_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign a_nan  = (&ea_raw) && (|fa);
    assign b_nan  = (&eb_raw) && (|fb);
    assign a_inf  = (&ea_raw) && !(|fa);
    assign b_inf  = (&eb_raw) && !(|fb);
    assign a_zero = !(|ea_raw) && !(|fa);
    assign b_zero = !(|eb_raw) && !(|fb);
    // Subnormals use exponent 1 with a cleared hidden bit.
    assign ea     = (|ea_raw) ? ea_raw : E_ONE;
    assign eb     = (|eb_raw) ? eb_raw : E_ONE;
    assign mA     = {(|ea_raw), fa, 3'b000};
    assign mB     = {(|eb_raw), fb, 3'b000};

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = (state_q == S_DONE);
    assign out_z     = z_q;
    assign ofw       = ofw_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        exp_d   = exp_q;
        m_d     = m_q;
        s_d     = s_q;
        z_d     = z_q;
        ofw_d   = ofw_q;
        sum_c   = '0;
        rnd_c   = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = op_a;
                    b_d     = {op_b[W-1] ^ sub, op_b[W-2:0]};
                    state_d = S_SPECIAL;
                end
            end
            S_SPECIAL: begin
                state_d = S_DONE;
                ofw_d   = 1'b0;
                if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1])))
                    z_d = QNAN;
                else if (a_inf)
                    z_d = a_q;
                else if (b_inf)
                    z_d = b_q;
                else if (a_zero && b_zero)
                    z_d = {a_q[W-1] & b_q[W-1], {(W-1){1'b0}}};
                else if (a_zero)
                    z_d = b_q;
                else if (b_zero)
                    z_d = a_q;
                else begin
                    z_d     = z_q;
                    ofw_d   = ofw_q;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // Operand with the larger exponent always lands in ma.
                if (ea >= eb) begin
                    ma_d  = mA;
                    mb_d  = align_shift(mB, ea - eb);
                    sa_d  = a_q[W-1];
                    sb_d  = b_q[W-1];
                    exp_d = {1'b0, ea};
                end else begin
                    ma_d  = mB;
                    mb_d  = align_shift(mA, eb - ea);
                    sa_d  = b_q[W-1];
                    sb_d  = a_q[W-1];
                    exp_d = {1'b0, eb};
                end
                state_d = S_ADD;
            end
            S_ADD: begin
                if (sa_q == sb_q) begin
                    sum_c = {1'b0, ma_q} + {1'b0, mb_q};
                    s_d   = sa_q;
                end else if (ma_q >= mb_q) begin
                    sum_c = {1'b0, ma_q} - {1'b0, mb_q};
                    s_d   = (sum_c == '0) ? 1'b0 : sa_q;
                end else begin
                    sum_c = {1'b0, mb_q} - {1'b0, ma_q};
                    s_d   = sb_q;
                end
                if (sum_c[MW]) begin
                    m_d   = {sum_c[MW:2], sum_c[1] | sum_c[0]};
                    exp_d = exp_q + {{EXP_W{1'b0}}, 1'b1};
                end else begin
                    m_d   = sum_c[MW-1:0];
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (!m_q[MW-1] && (exp_q > {{EXP_W{1'b0}}, 1'b1})) begin
                    m_d   = {m_q[MW-2:0], 1'b0};
                    exp_d = exp_q - {{EXP_W{1'b0}}, 1'b1};
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                rnd_c   = round_pack(s_q, exp_q, m_q);
                ofw_d   = rnd_c[W];
                z_d     = rnd_c[W-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            exp_q   <= '0;
            m_q     <= '0;
            s_q     <= 1'b0;
            z_q     <= '0;
            ofw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            exp_q   <= exp_d;
            m_q     <= m_d;
            s_q     <= s_d;
            z_q     <= z_d;
            ofw_q   <= ofw_d;
        end
    end

endmodule

// File: tb/tb_fp_addsub_param.sv
// Scoreboard bench for fp_addsub_param at single precision (EXP_W=8, MAN_W=23).
module tb_fp_addsub_param;

    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        ofw;

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .ofw       (ofw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic        ofw;
        logic [31:0] lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] z;
        logic        ofw;
        logic [31:0] lat;
        logic [31:0] hold;
    } vec_t;

`ifdef FP_ADDSUB_RNE_EN
    localparam logic [31:0] RND_Z = 32'h3F800002;
`else
    localparam logic [31:0] RND_Z = 32'h3F800001;
`endif

    exp_t sbq[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] ez, input logic eofw, input logic [31:0] elat,
                          input logic [31:0] hold);
        exp_t        e;
        exp_t        got;
        logic [31:0] n;
        e.z   = ez;
        e.ofw = eofw;
        e.lat = elat;
        sbq.push_back(e);
        @(negedge clk);
        op_a      = a;
        op_b      = b;
        sub       = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check_eq("in_ready_idle", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        sub      = 1'($urandom_range(0, 1));
        check_eq("in_ready_busy", {31'b0, in_ready}, 32'd0);
        n = 32'd1;
        while (!out_valid && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("out_valid_seen", {31'b0, out_valid}, 32'd1);
        got = sbq.pop_front();
        check_eq("z", out_z, got.z);
        check_eq("ofw", {31'b0, ofw}, {31'b0, got.ofw});
        check_eq("latency", n, got.lat);
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_z", out_z, got.z);
            check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
            check_eq("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("drain_valid", {31'b0, out_valid}, 32'd0);
        check_eq("drain_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("drain_z_held", out_z, got.z);
    endtask

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 32'd6,   32'd0};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 32'd132, 32'd0};
        vecs[2]  = '{32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 32'd7,   32'd0};
        vecs[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 32'd2,   32'd0};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 32'd6,   32'd0};
        vecs[5]  = '{32'h3F800000, 32'h34400000, 1'b0, RND_Z,        1'b0, 32'd6,   32'd0};
        vecs[6]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 32'd6,   32'd10};
        vecs[7]  = '{32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 1'b0, 32'd6,   32'd0};
        vecs[8]  = '{32'h40A00000, 32'h40400000, 1'b1, 32'h40000000, 1'b0, 32'd7,   32'd0};
        vecs[9]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 32'd7,   32'd0};
        vecs[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 32'd2,   32'd0};
        vecs[11] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 32'd2,   32'd0};
        vecs[12] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 32'd2,   32'd0};
        vecs[13] = '{32'h00000000, 32'hC0000000, 1'b0, 32'hC0000000, 1'b0, 32'd2,   32'd0};
        vecs[14] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 32'd6,   32'd0};
        vecs[15] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 32'd6,   32'd0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_z", out_z, 32'h0);
        check_eq("rst_ofw", {31'b0, ofw}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].z, vecs[i].ofw,
                   vecs[i].lat, vecs[i].hold);

        // Leave a non-zero result behind, then abort a cancellation while it normalises.
        run_op(32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 1'b0, 32'd6, 32'd0);
        @(negedge clk);
        op_a     = 32'h3F800000;
        op_b     = 32'h3F800000;
        sub      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check_eq("pre_abort_valid", {31'b0, out_valid}, 32'd0);
        check_eq("pre_abort_z", out_z, 32'h40A00000);
        reset = 1'b1;
        #1;
        check_eq("abort_valid", {31'b0, out_valid}, 32'd0);
        check_eq("abort_z", out_z, 32'h0);
        check_eq("abort_ofw", {31'b0, ofw}, 32'd0);
        check_eq("abort_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_result", {31'b0, out_valid}, 32'd0);
        end
        run_op(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 32'd7, 32'd0);

        check_eq("scoreboard_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
